rv32im_mul_ctrl: RTL and testbench



---
 rtl/rv32im_mul_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_rv32im_mul_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32im_mul_ctrl.sv
// Issue/retire controller between the RV32M execute stage and the shift-add multiplier core.
// Optional: define RV32IM_MULCTRL_REUSE_EN to reuse the last product for fused MULH*/MUL pairs.
module rv32im_mul_ctrl #(
  parameter int XLEN = 32
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [2:0]        req_funct3_i,
  input  logic [XLEN-1:0]   req_rs1_i,
  input  logic [XLEN-1:0]   req_rs2_i,
  input  logic              kill_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [XLEN-1:0]   resp_result_o,
  output logic              resp_illegal_o,
  output logic              mul_start_o,
  output logic [XLEN-1:0]   mul_operand1_o,
  output logic [XLEN-1:0]   mul_operand2_o,
  input  logic              mul_valid_i,
  input  logic [2*XLEN-1:0] mul_product_i
);

  localparam int PW = 2 * XLEN;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_SIGN,
    S_DONE,
    S_DRAIN
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [XLEN-1:0] r_op1;
  logic [XLEN-1:0] r_op2;
  logic [PW-1:0]   r_prod;
  logic [XLEN-1:0] r_result;
  logic            r_neg;
  logic            r_is_lo;
  logic            r_illegal;

  logic            w_accept;
  logic            w_illegal_req;
  logic            w_s1;
  logic            w_s2;
  logic            w_neg1;
  logic            w_neg2;
  logic [XLEN-1:0] w_mag1;
  logic [XLEN-1:0] w_mag2;
  logic [PW-1:0]   w_prod_fix;
  logic [XLEN-1:0] w_res;
  logic            w_hit;
  logic            w_take_hit;

  assign w_accept      = (r_state == S_IDLE) & req_valid_i & ~kill_i;
  assign w_illegal_req = req_funct3_i[2];

  always_comb begin
    w_s1 = 1'b0;
    w_s2 = 1'b0;
    unique case (1'b1)
      (req_funct3_i[1:0] == 2'b01): begin
        w_s1 = 1'b1;
        w_s2 = 1'b1;
      end
      (req_funct3_i[1:0] == 2'b10): w_s1 = 1'b1;
      default: ;
    endcase
  end

  assign w_neg1 = w_s1 & req_rs1_i[XLEN-1];
  assign w_neg2 = w_s2 & req_rs2_i[XLEN-1];
  assign w_mag1 = w_neg1 ? (XLEN'(0) - req_rs1_i) : req_rs1_i;
  assign w_mag2 = w_neg2 ? (XLEN'(0) - req_rs2_i) : req_rs2_i;

  assign w_prod_fix = r_neg ? (PW'(0) - r_prod) : r_prod;
  assign w_res      = r_is_lo ? w_prod_fix[XLEN-1:0]
                              : w_prod_fix[PW-1:XLEN];

`ifdef RV32IM_MULCTRL_REUSE_EN
  logic            r_c_vld;
  logic [PW-1:0]   r_c_prod;
  logic [XLEN-1:0] r_c_rs1;
  logic [XLEN-1:0] r_c_rs2;
  logic [1:0]      r_c_cls;
  logic [XLEN-1:0] r_rs1;
  logic [XLEN-1:0] r_rs2;
  logic [1:0]      r_cls;
  logic            r_hit;
  logic [1:0]      w_cls;

  // MUL runs unsigned, so its full product belongs to the MULHU class
  assign w_cls = (req_funct3_i[1:0] == 2'b00) ? 2'b11
                                              : req_funct3_i[1:0];

  assign w_hit = r_c_vld
               & (req_rs1_i == r_c_rs1)
               & (req_rs2_i == r_c_rs2)
               & ((req_funct3_i[1:0] == 2'b00)
                  | (w_cls == r_c_cls));

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_rs1 <= '0;
      r_rs2 <= '0;
      r_cls <= '0;
      r_hit <= 1'b0;
    end else if (w_accept) begin
      r_rs1 <= req_rs1_i;
      r_rs2 <= req_rs2_i;
      r_cls <= w_cls;
      r_hit <= w_take_hit;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_c_vld  <= 1'b0;
      r_c_prod <= '0;
      r_c_rs1  <= '0;
      r_c_rs2  <= '0;
      r_c_cls  <= '0;
    end else if (kill_i || (w_accept && w_illegal_req)) begin
      r_c_vld <= 1'b0;
    end else if (r_state == S_SIGN && !r_hit) begin
      r_c_vld  <= 1'b1;
      r_c_prod <= w_prod_fix;
      r_c_rs1  <= r_rs1;
      r_c_rs2  <= r_rs2;
      r_c_cls  <= r_cls;
    end
  end
`else
  assign w_hit = 1'b0;
`endif

  assign w_take_hit = w_hit & ~w_illegal_req;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) r_state <= S_IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_illegal_req)   w_next = S_DONE;
          else if (w_take_hit) w_next = S_SIGN;
          else                 w_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_next = kill_i ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        // a kill landing on the completion cycle has nothing left to drain
        if (kill_i)           w_next = mul_valid_i ? S_IDLE : S_DRAIN;
        else if (mul_valid_i) w_next = S_SIGN;
      end
      S_SIGN: begin
        w_next = kill_i ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        if (kill_i || resp_ready_i) w_next = S_IDLE;
      end
      S_DRAIN: begin
        if (mul_valid_i) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o    = 1'b0;
    mul_start_o    = 1'b0;
    resp_valid_o   = 1'b0;
    resp_result_o  = '0;
    resp_illegal_o = 1'b0;
    unique case (r_state)
      S_IDLE:  req_ready_o = 1'b1;
      S_ISSUE: mul_start_o = 1'b1;
      S_DONE: begin
        resp_valid_o   = 1'b1;
        resp_result_o  = r_result;
        resp_illegal_o = r_illegal;
      end
      default: ;
    endcase
  end

  assign mul_operand1_o = r_op1;
  assign mul_operand2_o = r_op2;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_op1     <= '0;
      r_op2     <= '0;
      r_prod    <= '0;
      r_result  <= '0;
      r_neg     <= 1'b0;
      r_is_lo   <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      if (w_accept) begin
        r_is_lo   <= (req_funct3_i[1:0] == 2'b00);
        r_illegal <= w_illegal_req;
        r_result  <= '0;
        if (!w_illegal_req) begin
          r_op1 <= w_mag1;
          r_op2 <= w_mag2;
          r_neg <= w_neg1 ^ w_neg2;
        end
`ifdef RV32IM_MULCTRL_REUSE_EN
        // cached product is already sign-corrected
        if (w_take_hit) begin
          r_prod <= r_c_prod;
          r_neg  <= 1'b0;
        end
`endif
      end
      if (r_state == S_WAIT && mul_valid_i && !kill_i) begin
        r_prod <= mul_product_i;
      end
      if (r_state == S_SIGN && !kill_i) begin
        r_result <= w_res;
      end
    end
  end

endmodule

// File: tb/tb_rv32im_mul_ctrl.sv
// Directed testbench for rv32im_mul_ctrl with a 4-cycle behavioural multiplier core.
// Define RV32IM_MULCTRL_REUSE_EN to also exercise product reuse.
module tb_rv32im_mul_ctrl;

  logic        clk = 1'b0;
  logic        reset_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_rs1_i;
  logic [31:0] req_rs2_i;
  logic        kill_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_result_o;
  logic        resp_illegal_o;
  logic        mul_start_o;
  logic [31:0] mul_operand1_o;
  logic [31:0] mul_operand2_o;
  logic        mul_valid_i;
  logic [63:0] mul_product_i;

  int n_assert = 0;
  int n_fail   = 0;
  int n_start  = 0;

  always #5 clk = ~clk;

  rv32im_mul_ctrl #(.XLEN(32)) dut (
    .clk_i          (clk),
    .reset_ni       (reset_ni),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_funct3_i   (req_funct3_i),
    .req_rs1_i      (req_rs1_i),
    .req_rs2_i      (req_rs2_i),
    .kill_i         (kill_i),
    .resp_valid_o   (resp_valid_o),
    .resp_ready_i   (resp_ready_i),
    .resp_result_o  (resp_result_o),
    .resp_illegal_o (resp_illegal_o),
    .mul_start_o    (mul_start_o),
    .mul_operand1_o (mul_operand1_o),
    .mul_operand2_o (mul_operand2_o),
    .mul_valid_i    (mul_valid_i),
    .mul_product_i  (mul_product_i)
  );

  logic [31:0] m_a, m_b;
  logic        m_busy;
  int          m_cnt;

  always @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      mul_valid_i   <= 1'b0;
      mul_product_i <= '0;
      m_busy        <= 1'b0;
      m_cnt         <= 0;
    end else begin
      mul_valid_i <= 1'b0;
      if (mul_start_o) begin
        n_start <= n_start + 1;
        m_busy  <= 1'b1;
        m_cnt   <= 4;
        m_a     <= mul_operand1_o;
        m_b     <= mul_operand2_o;
      end else if (m_busy) begin
        if (m_cnt == 1) begin
          mul_valid_i   <= 1'b1;
          mul_product_i <= {32'b0, m_a} * {32'b0, m_b};
          m_busy        <= 1'b0;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // e_lat < 0: response must trail the core's valid by 2 cycles
  task automatic run_op(string tag, logic [2:0] f3,
                        logic [31:0] a, logic [31:0] b,
                        logic [31:0] e_op1, logic [31:0] e_op2,
                        logic [31:0] e_res, logic e_ill,
                        int e_nst, int e_lat, int hold);
    int s0, iv, ir;
    logic [31:0] c1, c2;
    c1 = '0;
    c2 = '0;
    iv = -100;
    ir = -1;
    s0 = n_start;
    chk({tag, "_rdy"}, 64'(req_ready_o), 64'd1);
    req_valid_i  = 1'b1;
    req_funct3_i = f3;
    req_rs1_i    = a;
    req_rs2_i    = b;
    step();
    req_valid_i = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (mul_start_o) begin
        c1 = mul_operand1_o;
        c2 = mul_operand2_o;
      end
      if (mul_valid_i) iv = i;
      if (resp_valid_o) begin
        ir = i;
        break;
      end
      step();
    end
    chk({tag, "_resp_seen"}, 64'(ir >= 0), 64'd1);
    if (e_lat < 0) chk({tag, "_lat"}, 64'(ir - iv), 64'd2);
    else           chk({tag, "_lat"}, 64'(ir), 64'(e_lat));
    chk({tag, "_starts"}, 64'(n_start - s0), 64'(e_nst));
    if (e_nst > 0) begin
      chk({tag, "_op1"}, 64'(c1), 64'(e_op1));
      chk({tag, "_op2"}, 64'(c2), 64'(e_op2));
    end
    chk({tag, "_res"}, 64'(resp_result_o), 64'(e_res));
    chk({tag, "_ill"}, 64'(resp_illegal_o), 64'(e_ill));
    for (int k = 0; k < hold; k++) begin
      step();
      chk({tag, "_hold_v"}, 64'(resp_valid_o), 64'd1);
      chk({tag, "_hold_r"}, 64'(resp_result_o), 64'(e_res));
      chk({tag, "_hold_rdy"}, 64'(req_ready_o), 64'd0);
    end
    resp_ready_i = 1'b1;
    step();
    resp_ready_i = 1'b0;
    chk({tag, "_post_v"}, 64'(resp_valid_o), 64'd0);
    chk({tag, "_post_rdy"}, 64'(req_ready_o), 64'd1);
  endtask

  initial begin
    int s0;
    logic bad;
    logic got;
    reset_ni     = 1'b0;
    req_valid_i  = 1'b0;
    req_funct3_i = '0;
    req_rs1_i    = '0;
    req_rs2_i    = '0;
    kill_i       = 1'b0;
    resp_ready_i = 1'b0;
    #12;
    chk("rst_rdy",   64'(req_ready_o),    64'd1);
    chk("rst_valid", 64'(resp_valid_o),   64'd0);
    chk("rst_start", 64'(mul_start_o),    64'd0);
    chk("rst_res",   64'(resp_result_o),  64'd0);
    chk("rst_ill",   64'(resp_illegal_o), 64'd0);
    chk("rst_op1",   64'(mul_operand1_o), 64'd0);
    chk("rst_op2",   64'(mul_operand2_o), 64'd0);
    reset_ni = 1'b1;
    step();

    run_op("mulhu_ff", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF,
           32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1, -1, 0);
    run_op("mulhsu_ff", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF,
           32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1, -1, 0);
    run_op("mul_7", 3'b000, 32'd7, 32'hFFFFFFFD,
           32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 1, -1, 0);
    run_op("mulh_min", 3'b001, 32'h80000000, 32'h80000000,
           32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 1, -1, 0);
    run_op("mulh_neg", 3'b001, 32'hFFFFFFFD, 32'd5,
           32'd3, 32'd5, 32'hFFFFFFFF, 1'b0, 1, -1, 0);
    run_op("mulh_zero", 3'b001, 32'd0, 32'hFFFFFFFF,
           32'd0, 32'd1, 32'd0, 1'b0, 1, -1, 0);
    run_op("mulhsu_min", 3'b010, 32'h80000000, 32'd2,
           32'h80000000, 32'd2, 32'hFFFFFFFF, 1'b0, 1, -1, 0);
    run_op("hold5", 3'b011, 32'h12345678, 32'h00010000,
           32'h12345678, 32'h00010000, 32'h00001234, 1'b0, 1, -1, 5);
    run_op("illegal", 3'b101, 32'h11, 32'h22,
           32'h0, 32'h0, 32'h0, 1'b1, 0, 0, 0);

    // kill three cycles after the start pulse
    s0  = n_start;
    bad = 1'b0;
    got = 1'b0;
    req_valid_i  = 1'b1;
    req_funct3_i = 3'b001;
    req_rs1_i    = 32'd5;
    req_rs2_i    = 32'd6;
    step();
    req_valid_i = 1'b0;
    chk("kill_start", 64'(mul_start_o), 64'd1);
    step();
    step();
    step();
    kill_i = 1'b1;
    step();
    kill_i = 1'b0;
    chk("kill_drain_rdy", 64'(req_ready_o), 64'd0);
    for (int i = 0; i < 20; i++) begin
      if (resp_valid_o || req_ready_o) bad = 1'b1;
      if (mul_valid_i) begin
        got = 1'b1;
        break;
      end
      step();
    end
    chk("kill_core_done", 64'(got), 64'd1);
    chk("kill_no_resp", 64'(bad), 64'd0);
    step();
    chk("kill_rdy_back", 64'(req_ready_o), 64'd1);
    chk("kill_valid", 64'(resp_valid_o), 64'd0);
    chk("kill_starts", 64'(n_start - s0), 64'd1);

    // kill in IDLE blocks a same-cycle request
    s0 = n_start;
    req_valid_i  = 1'b1;
    req_funct3_i = 3'b011;
    kill_i       = 1'b1;
    step();
    req_valid_i = 1'b0;
    kill_i      = 1'b0;
    chk("kill_idle_rdy", 64'(req_ready_o), 64'd1);
    step();
    chk("kill_idle_starts", 64'(n_start - s0), 64'd0);

    // kill in DONE drops the response
    got = 1'b0;
    req_valid_i  = 1'b1;
    req_funct3_i = 3'b011;
    req_rs1_i    = 32'd9;
    req_rs2_i    = 32'd9;
    step();
    req_valid_i = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (resp_valid_o) begin
        got = 1'b1;
        break;
      end
      step();
    end
    chk("kdone_seen", 64'(got), 64'd1);
    kill_i = 1'b1;
    step();
    kill_i = 1'b0;
    chk("kdone_valid", 64'(resp_valid_o), 64'd0);
    chk("kdone_rdy", 64'(req_ready_o), 64'd1);

    // asynchronous reset mid-operation
    req_valid_i  = 1'b1;
    req_funct3_i = 3'b001;
    req_rs1_i    = 32'd4;
    req_rs2_i    = 32'd4;
    step();
    req_valid_i = 1'b0;
    step();
    reset_ni = 1'b0;
    #1;
    chk("mrst_rdy", 64'(req_ready_o), 64'd1);
    chk("mrst_op1", 64'(mul_operand1_o), 64'd0);
    step();
    reset_ni = 1'b1;
    step();
    run_op("after_rst", 3'b000, 32'd6, 32'd7,
           32'd6, 32'd7, 32'd42, 1'b0, 1, -1, 0);

`ifdef RV32IM_MULCTRL_REUSE_EN
    run_op("reuse_mulh", 3'b001, 32'd3, 32'hFFFFFFFB,
           32'd3, 32'd5, 32'hFFFFFFFF, 1'b0, 1, -1, 0);
    run_op("reuse_mul", 3'b000, 32'd3, 32'hFFFFFFFB,
           32'd0, 32'd0, 32'hFFFFFFF1, 1'b0, 0, 1, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
